lii_in_unpack_mux: RTL



---
 rtl/lii_in_unpack_mux.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lii_in_unpack_mux.sv
// LII phy-input unpacker: steers phy beats by src id into per-stream FIFOs,
// with a round-robin arbiter per stream, bad-id drop counting and kernel ce.

module lii_in_unpack_lane #(
    parameter int P     = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [P-1:0]          req,
    input  logic [P-1:0][DW-1:0]  wdata,
    output logic [P-1:0]          gnt,
    output logic [DW-1:0]         rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  full
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PIW = (P > 1) ? $clog2(P) : 1;

    logic [PIW-1:0] rr;
    logic [PIW-1:0] win;
    logic [PIW-1:0] idx;
    logic [PIW:0]   sum_idx;
    logic           push;
    logic           pop;
    logic [DW-1:0]  wd;
    logic [AW:0]    count;
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [DW-1:0]  mem [DEPTH];

    assign full   = (count == (AW+1)'(DEPTH));
    assign rvalid = (count != '0);
    assign rdata  = mem[rptr];
    assign pop    = rvalid & rready;

    // Search starts at rr and wraps; a full FIFO grants nobody, even if popping.
    always_comb begin
        gnt     = '0;
        push    = 1'b0;
        win     = '0;
        idx     = '0;
        sum_idx = '0;
        for (int k = 0; k < P; k++) begin
            sum_idx = {1'b0, rr} + (PIW+1)'(k);
            if (sum_idx >= (PIW+1)'(P))
                sum_idx = sum_idx - (PIW+1)'(P);
            idx = sum_idx[PIW-1:0];
            if (!push && !full && req[idx]) begin
                push     = 1'b1;
                gnt[idx] = 1'b1;
                win      = idx;
            end
        end
    end

    always_comb begin
        wd = '0;
        for (int p = 0; p < P; p++)
            if (gnt[p])
                wd = wd | wdata[p];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wd;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            rr    <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
                rr   <= (win == PIW'(P-1)) ? '0 : win + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module lii_in_unpack_mux #(
    parameter int NIN     = 2,
    parameter int P       = 2,
    parameter int PW      = 64,
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int ID_BASE = 0
) (
    input  logic              aclk,
    input  logic              arstn,
    input  logic [P*PW-1:0]   lii_in_tdata,
    input  logic [P-1:0]      lii_in_tvalid,
    output logic [P-1:0]      lii_in_tready,
    input  logic [P*8-1:0]    lii_in_src,
    input  logic [P*8-1:0]    lii_in_dst,
    output logic [NIN*DW-1:0] out_tdata,
    output logic [NIN-1:0]    out_tvalid,
    input  logic [NIN-1:0]    out_tready,
    output logic              ce,
    output logic [15:0]       drop_cnt
);
    logic [P-1:0][7:0]      id;
    logic [P-1:0]           good;
    logic [P-1:0]           bad;
    logic [P-1:0]           granted;
    logic [P-1:0][DW-1:0]   wdata;
    logic [NIN-1:0][P-1:0]  req;
    logic [NIN-1:0][P-1:0]  gnt;
    logic [NIN-1:0]         full;
    logic [16:0]            drop_sum;
    logic                   unused_bits;

    // dst is reserved and the upper PW-DW data bits are dropped by design.
    assign unused_bits = ^{lii_in_dst, lii_in_tdata};

    for (genvar p = 0; p < P; p++) begin : g_ch
        assign id[p]    = lii_in_src[p*8 +: 8] - 8'(ID_BASE);
        assign good[p]  = (id[p] < 8'(NIN));
        assign bad[p]   = lii_in_tvalid[p] & ~good[p];
        assign wdata[p] = lii_in_tdata[p*PW +: DW];
    end

    for (genvar n = 0; n < NIN; n++) begin : g_stream
        for (genvar p = 0; p < P; p++) begin : g_req
            assign req[n][p] = lii_in_tvalid[p] & good[p] & (id[p] == 8'(n));
        end

        lii_in_unpack_lane #(.P(P), .DW(DW), .DEPTH(DEPTH)) u_lane (
            .clk    (aclk),
            .rstn   (arstn),
            .req    (req[n]),
            .wdata  (wdata),
            .gnt    (gnt[n]),
            .rdata  (out_tdata[n*DW +: DW]),
            .rvalid (out_tvalid[n]),
            .rready (out_tready[n]),
            .full   (full[n])
        );
    end

    always_comb begin
        granted = '0;
        for (int n = 0; n < NIN; n++)
            granted = granted | gnt[n];
    end

    assign lii_in_tready = arstn ? (bad | granted) : '0;
    assign ce            = ~|full;

    always_comb begin
        drop_sum = {1'b0, drop_cnt};
        for (int p = 0; p < P; p++)
            if (bad[p] && lii_in_tready[p])
                drop_sum = drop_sum + 17'd1;
    end

    always_ff @(posedge aclk) begin
        if (!arstn)
            drop_cnt <= '0;
        else
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
endmodule
